// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO read through the IO page.
// rx_state exposes the receive FSM state (0 idle, 1 start, 2 data, 3 stop).
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int BAUD_RATE       = 1_000_000,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  input  logic       rstrb,
  input  logic       clr_err,
  output logic [7:0] rdata,
  output logic       rx_avail,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err,
  output logic [1:0] rx_state
);

  localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW    = $clog2(CPB);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic          push;
  logic          rx_meta, rxs;

  assign rx_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // shreg holds the finished byte while push is high; it only changes again in DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push <= 1'b0;
      if (clr_err) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= CW'(CPB / 2 - 1);
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (rxs) state <= IDLE;
          else begin
            cnt    <= CW'(CPB - 1);
            bitidx <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= CW'(CPB - 1);
            if (bitidx == 3'd7) state <= STOP;
            else bitidx <= bitidx + 3'd1;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            if (rxs) push <= 1'b1;
            else frame_err <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rx_avail = !empty;
  assign rx_full  = full;
  // rstrb is a one-cycle read strobe; rdata holds the popped byte (or 0 if empty)
  // from the following cycle. A pop in the push cycle frees the slot for that push.
  assign do_pop   = rstrb && !empty;
  assign do_push  = push && (!full || rstrb);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rdata   <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (rstrb) rdata <= empty ? 8'h00 : mem[rd_ptr];
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !rstrb) overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at CPB=100, depth 4: directed scenarios plus random frames
// against a queue-based model; popped bytes are checked by a separate monitor.
module tb_uart_rx_fifo;
  localparam int CPB   = 100;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, RXD, rstrb, clr_err;
  logic [7:0] rdata;
  logic       rx_avail, rx_full, overrun, frame_err;
  logic [1:0] rx_state;

  uart_rx_fifo #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .RXD(RXD), .rstrb(rstrb), .clr_err(clr_err),
    .rdata(rdata), .rx_avail(rx_avail), .rx_full(rx_full), .overrun(overrun),
    .frame_err(frame_err), .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];
  logic       model_ovr, model_fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_pop();
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    else exp_q.push_back(8'h00);
  endtask

  task automatic model_clear_flags();
    model_ovr = 1'b0;
    model_fe  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":rx_avail"}, rx_avail, model_q.size() != 0);
    chk({tag, ":rx_full"}, rx_full, model_q.size() == DEPTH);
    chk({tag, ":overrun"}, overrun, model_ovr);
    chk({tag, ":frame_err"}, frame_err, model_fe);
  endtask

  task automatic do_read();
    @(negedge clk);
    rstrb = 1'b1;
    model_pop();
    @(negedge clk);
    rstrb = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr_err = 1'b1;
    model_clear_flags();
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; negedge k counts from the start-bit edge. A pop at k lands
  // on the following posedge; clr_err is held high for k < clr_until.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at,
                            input int clr_until, output int avail_at);
    logic [9:0] bits;
    logic       was_avail;
    bits = {stop_bit, b, 1'b0};
    avail_at = -1;
    @(negedge clk);
    was_avail = rx_avail;
    if (clr_until > 0) model_clear_flags();
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (avail_at < 0 && !was_avail && rx_avail) avail_at = k;
      RXD     = bits[k / CPB];
      rstrb   = (k == pop_at);
      clr_err = (k < clr_until);
      if (k == pop_at) model_pop();
    end
    @(negedge clk);
    rstrb   = 1'b0;
    clr_err = 1'b0;
    if (!stop_bit) model_fe = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endtask

  // Monitor: every accepted read strobe yields one byte on rdata the next cycle.
  always @(posedge clk) begin
    logic was_rd;
    logic [7:0] e;
    was_rd = rstrb && !reset;
    #1;
    if (was_rd) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rdata_unexpected: got %0h expected none", rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int av;
    reset = 1'b1; RXD = 1'b1; rstrb = 1'b0; clr_err = 1'b0;
    model_clear_flags();
    idle(5);
    chk("reset:rdata", rdata, 8'h00);
    check_state("reset");
    reset = 1'b0;
    idle(20);

    // 1: single frame, latency window, read, then read of empty FIFO
    send_frame(8'h55, 1'b1, -1, 0, av);
    chk($sformatf("t1:avail_latency_%0d", av), (av >= 952 && av <= 956), 1'b1);
    check_state("t1");
    do_read();
    check_state("t1_after_read");
    do_read();

    // 2: short glitch is ignored
    @(negedge clk); RXD = 1'b0;
    idle(30);
    RXD = 1'b1;
    idle(200);
    check_state("t2");

    // 3: five back-to-back frames, overrun on the fifth
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, 0, av);
      check_state($sformatf("t3_frame%0d", i));
    end
    for (int i = 0; i < 4; i++) do_read();
    check_state("t3_drained");
    clr_pulse();
    check_state("t3_cleared");

    // 4: pop coinciding with the push into a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, -1, 0, av);
    check_state("t4_full");
    send_frame(8'h66, 1'b1, 953, 0, av);
    check_state("t4_after");
    for (int i = 0; i < 4; i++) do_read();
    check_state("t4_drained");

    // 5: bad stop bit; clr_err held through the error cycle loses to the set
    send_frame(8'hA3, 1'b0, -1, 953, av);
    check_state("t5_ferr");
    clr_pulse();
    check_state("t5_cleared");

    // 6: reset in the middle of a data byte
    @(negedge clk); RXD = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      RXD = i[0];
      idle(CPB);
    end
    reset = 1'b1;
    model_q.delete();
    model_clear_flags();
    idle(3);
    chk("t6_reset:rdata", rdata, 8'h00);
    check_state("t6_reset");
    RXD = 1'b1;
    reset = 1'b0;
    idle(300);
    check_state("t6_idle");
    send_frame(8'h7E, 1'b1, -1, 0, av);
    check_state("t6_rx");
    do_read();
    check_state("t6_read");

    // random frames against the model
    for (int it = 0; it < 8; it++) begin
      logic [7:0] b;
      logic       sb;
      int         nr;
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 7) != 0);
      idle($urandom_range(0, 50));
      send_frame(b, sb, -1, 0, av);
      check_state($sformatf("rnd%0d_rx", it));
      nr = $urandom_range(0, 2);
      for (int r = 0; r < nr; r++) do_read();
      if ($urandom_range(0, 3) == 0) clr_pulse();
      check_state($sformatf("rnd%0d_post", it));
    end

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL pending_reads: got %0d expected 0", exp_q.size());
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
